// File: rtl/mode_counter_pkg.sv
// Shared definitions for the mode_counter block: the Mode encodings
// used by the top and by anything that drives it.
package mode_counter_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

endpackage

// File: rtl/mode_counter_prescaler.sv
// Tick generator: divides enabled cycles by PRESCALE. En freezes the count
// without clearing it; Clr restarts the period from zero.
module mode_counter_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic En,
    input  logic Clr,
    output logic Tick
);

    generate
        if (PRESCALE <= 1) begin : g_direct
            // Every enabled cycle is a tick; nothing to store.
            logic unused_ports;
            assign unused_ports = &{1'b0, Clock, Reset_n, Clr};
            assign Tick = En;
        end else begin : g_count
            localparam int CW = $clog2(PRESCALE);
            localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
            localparam logic [CW-1:0] ONE  = CW'(1);

            logic [CW-1:0] count;

            always_ff @(posedge Clock or negedge Reset_n) begin
                if (!Reset_n) begin
                    count <= '0;
                end else if (Clr) begin
                    count <= '0;
                end else if (En) begin
                    count <= (count == LAST) ? '0 : count + ONE;
                end
            end

            assign Tick = En && (count == LAST);
        end
    endgenerate

endmodule

// File: rtl/mode_counter.sv
// Prescaled up/down/bounce counter with load, wrap/saturate selection and
// a registered terminal-count pulse; Q/Dir/Tc drive pins directly.
module mode_counter
    import mode_counter_pkg::*;
#(
    parameter int              WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAX     = {WIDTH{1'b1}},
    parameter int              PRESCALE = 1
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             En,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       Mode,
    input  logic             Wrap,
    output logic [WIDTH-1:0] Q,
    output logic             Tc,
    output logic             Dir
);

    localparam logic [WIDTH-1:0] MAXV = MAX;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    // Widened compare keeps the clamp meaningful even when MAX is all ones.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return ({1'b0, v} > {1'b0, MAXV}) ? MAXV : v;
    endfunction

    function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v);
        return v + ONE;
    endfunction

    function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] v);
        return v - ONE;
    endfunction

    logic             tick;
    mode_t            mode_sel;
    logic [WIDTH-1:0] q_next;
    logic             dir_next;
    logic             tc_next;

    assign mode_sel = mode_t'(Mode);

    mode_counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .En      (En),
        .Clr     (Load),
        .Tick    (tick)
    );

    always_comb begin
        q_next   = Q;
        dir_next = Dir;
        tc_next  = 1'b0;
        if (Load) begin
            q_next = clamp_load(D);
            if (mode_sel == MODE_UP) begin
                dir_next = 1'b0;
            end else if (mode_sel == MODE_DOWN) begin
                dir_next = 1'b1;
            end
        end else if (tick) begin
            case (mode_sel)
                MODE_UP: begin
                    dir_next = 1'b0;
                    if (Q == MAXV) begin
                        q_next  = Wrap ? '0 : MAXV;
                        tc_next = 1'b1;
                    end else begin
                        q_next = step_up(Q);
                    end
                end
                MODE_DOWN: begin
                    dir_next = 1'b1;
                    if (Q == '0) begin
                        q_next  = Wrap ? MAXV : '0;
                        tc_next = 1'b1;
                    end else begin
                        q_next = step_down(Q);
                    end
                end
                MODE_BOUNCE: begin
                    // A zero-length range has nowhere to bounce to.
                    if (MAXV == '0) begin
                        q_next  = '0;
                        tc_next = 1'b1;
                    end else if (!Dir) begin
                        if (Q == MAXV) begin
                            q_next   = step_down(MAXV);
                            dir_next = 1'b1;
                            tc_next  = 1'b1;
                        end else begin
                            q_next = step_up(Q);
                        end
                    end else begin
                        if (Q == '0) begin
                            q_next   = ONE;
                            dir_next = 1'b0;
                            tc_next  = 1'b1;
                        end else begin
                            q_next = step_down(Q);
                        end
                    end
                end
                default: begin
                    q_next   = Q;
                    dir_next = Dir;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Q   <= '0;
            Dir <= 1'b0;
            Tc  <= 1'b0;
        end else begin
            Q   <= q_next;
            Dir <= dir_next;
            Tc  <= tc_next;
        end
    end

endmodule

// File: tb/tb_mode_counter.sv
// Directed bench for mode_counter: four instances with different MAX and
// PRESCALE, driven from a vector table plus hand-written reset sequences.
module tb_mode_counter;
    import mode_counter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en_a   [4];
    logic       load_a [4];
    logic       wrap_a [4];
    logic [3:0] d_a    [4];
    logic [1:0] mode_a [4];
    logic [3:0] q_a    [4];
    logic       tc_a   [4];
    logic       dir_a  [4];

    mode_counter #(.WIDTH(4), .MAX(4'd15), .PRESCALE(1)) u0 (
        .Clock(clk), .Reset_n(rst_n), .En(en_a[0]), .Load(load_a[0]), .D(d_a[0]),
        .Mode(mode_a[0]), .Wrap(wrap_a[0]), .Q(q_a[0]), .Tc(tc_a[0]), .Dir(dir_a[0]));
    mode_counter #(.WIDTH(4), .MAX(4'd9), .PRESCALE(1)) u1 (
        .Clock(clk), .Reset_n(rst_n), .En(en_a[1]), .Load(load_a[1]), .D(d_a[1]),
        .Mode(mode_a[1]), .Wrap(wrap_a[1]), .Q(q_a[1]), .Tc(tc_a[1]), .Dir(dir_a[1]));
    mode_counter #(.WIDTH(4), .MAX(4'd5), .PRESCALE(1)) u2 (
        .Clock(clk), .Reset_n(rst_n), .En(en_a[2]), .Load(load_a[2]), .D(d_a[2]),
        .Mode(mode_a[2]), .Wrap(wrap_a[2]), .Q(q_a[2]), .Tc(tc_a[2]), .Dir(dir_a[2]));
    mode_counter #(.WIDTH(4), .MAX(4'd9), .PRESCALE(3)) u3 (
        .Clock(clk), .Reset_n(rst_n), .En(en_a[3]), .Load(load_a[3]), .D(d_a[3]),
        .Mode(mode_a[3]), .Wrap(wrap_a[3]), .Q(q_a[3]), .Tc(tc_a[3]), .Dir(dir_a[3]));

    typedef struct {
        int         idx;
        logic       en;
        logic       load;
        logic [3:0] d;
        logic [1:0] mode;
        logic       wrap;
        logic [3:0] q;
        logic       tc;
        logic       dir;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input int idx, input int en, input int load, input int d,
                       input int mode, input int wrap, input int q, input int tc,
                       input int dir);
        vec_t v;
        v.idx  = idx;
        v.en   = en[0];
        v.load = load[0];
        v.d    = d[3:0];
        v.mode = mode[1:0];
        v.wrap = wrap[0];
        v.q    = q[3:0];
        v.tc   = tc[0];
        v.dir  = dir[0];
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input int q,
                         input int tc, input int dir);
        checks++;
        if ({q_a[idx], tc_a[idx], dir_a[idx]} !== {q[3:0], tc[0], dir[0]}) begin
            errors++;
            $display("FAIL %s dut%0d: got Q=%0d Tc=%b Dir=%b, expected Q=%0d Tc=%b Dir=%b",
                     name, idx, q_a[idx], tc_a[idx], dir_a[idx], q[3:0], tc[0], dir[0]);
        end
    endtask

    task automatic clear_strobes();
        for (int i = 0; i < 4; i++) begin
            en_a[i]   = 1'b0;
            load_a[i] = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            en_a[i] = 1'b0; load_a[i] = 1'b0; wrap_a[i] = 1'b1;
            d_a[i] = 4'd0; mode_a[i] = MODE_UP;
        end

        // Wrap-up on MAX=15: 1..15, then 0 with Tc, then 1.
        for (int i = 1; i <= 15; i++) add(0, 1, 0, 0, MODE_UP, 1, i, 0, 0);
        add(0, 1, 0, 0, MODE_UP, 1, 0, 1, 0);
        add(0, 1, 0, 0, MODE_UP, 1, 1, 0, 0);
        // Saturating up, then hold and disable.
        add(0, 0, 1, 14, MODE_UP,   0, 14, 0, 0);
        add(0, 1, 0, 0,  MODE_UP,   0, 15, 0, 0);
        add(0, 1, 0, 0,  MODE_UP,   0, 15, 1, 0);
        add(0, 1, 0, 0,  MODE_UP,   0, 15, 1, 0);
        add(0, 1, 0, 0,  MODE_HOLD, 0, 15, 0, 0);
        add(0, 0, 0, 0,  MODE_UP,   0, 15, 0, 0);

        // Saturating down on MAX=9 from a load of 3.
        add(1, 0, 1, 3, MODE_DOWN, 0, 3, 0, 1);
        add(1, 1, 0, 0, MODE_DOWN, 0, 2, 0, 1);
        add(1, 1, 0, 0, MODE_DOWN, 0, 1, 0, 1);
        add(1, 1, 0, 0, MODE_DOWN, 0, 0, 0, 1);
        add(1, 1, 0, 0, MODE_DOWN, 0, 0, 1, 1);
        add(1, 1, 0, 0, MODE_DOWN, 0, 0, 1, 1);
        // Load clamps to MAX and beats a coincident tick; wrap down from 0.
        add(1, 1, 1, 15, MODE_DOWN, 1, 9, 0, 1);
        add(1, 1, 0, 0,  MODE_DOWN, 1, 8, 0, 1);
        add(1, 0, 1, 0,  MODE_DOWN, 1, 0, 0, 1);
        add(1, 1, 0, 0,  MODE_DOWN, 1, 9, 1, 1);
        add(1, 0, 1, 4,  MODE_UP,   1, 4, 0, 0);

        // Bounce on MAX=5.
        for (int i = 1; i <= 5; i++) add(2, 1, 0, 0, MODE_BOUNCE, 1, i, 0, 0);
        add(2, 1, 0, 0, MODE_BOUNCE, 1, 4, 1, 1);
        for (int i = 3; i >= 0; i--) add(2, 1, 0, 0, MODE_BOUNCE, 1, i, 0, 1);
        add(2, 1, 0, 0, MODE_BOUNCE, 0, 1, 1, 0);
        add(2, 1, 0, 0, MODE_BOUNCE, 0, 2, 0, 0);
        // Mode changes mid-count; bounce keeps the current direction.
        add(2, 1, 0, 0, MODE_UP,     1, 3, 0, 0);
        add(2, 1, 0, 0, MODE_DOWN,   1, 2, 0, 1);
        add(2, 1, 0, 0, MODE_BOUNCE, 1, 1, 0, 1);
        add(2, 0, 1, 4, MODE_BOUNCE, 1, 4, 0, 1);

        // PRESCALE=3 with En dropped for two cycles mid-period.
        add(3, 1, 0, 0, MODE_UP, 1, 0, 0, 0);
        add(3, 1, 0, 0, MODE_UP, 1, 0, 0, 0);
        add(3, 1, 0, 0, MODE_UP, 1, 1, 0, 0);
        add(3, 1, 0, 0, MODE_UP, 1, 1, 0, 0);
        add(3, 0, 0, 0, MODE_UP, 1, 1, 0, 0);
        add(3, 0, 0, 0, MODE_UP, 1, 1, 0, 0);
        add(3, 1, 0, 0, MODE_UP, 1, 1, 0, 0);
        add(3, 1, 0, 0, MODE_UP, 1, 2, 0, 0);
        // Load of 15 lands on the tick cycle: clamp to 9, prescaler restarts.
        add(3, 1, 0, 0,  MODE_UP, 1, 2, 0, 0);
        add(3, 1, 0, 0,  MODE_UP, 1, 2, 0, 0);
        add(3, 1, 1, 15, MODE_UP, 1, 9, 0, 0);
        add(3, 1, 0, 0,  MODE_UP, 1, 9, 0, 0);
        add(3, 1, 0, 0,  MODE_UP, 1, 9, 0, 0);
        add(3, 1, 0, 0,  MODE_UP, 1, 0, 1, 0);

        #12 rst_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) check("reset_state", i, 0, 0, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            clear_strobes();
            en_a[vecs[k].idx]   = vecs[k].en;
            load_a[vecs[k].idx] = vecs[k].load;
            d_a[vecs[k].idx]    = vecs[k].d;
            mode_a[vecs[k].idx] = vecs[k].mode;
            wrap_a[vecs[k].idx] = vecs[k].wrap;
            step();
            check($sformatf("vec%0d", k), vecs[k].idx, vecs[k].q, vecs[k].tc, vecs[k].dir);
        end

        // Asynchronous reset between edges with Q=7, Dir=1.
        clear_strobes();
        load_a[0] = 1'b1; d_a[0] = 4'd8; mode_a[0] = MODE_DOWN; wrap_a[0] = 1'b1;
        step();
        check("pre_reset_load", 0, 8, 0, 1);
        load_a[0] = 1'b0; en_a[0] = 1'b1;
        step();
        check("pre_reset_tick", 0, 7, 0, 1);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_u0", 0, 0, 0, 0);
        check("async_reset_u2", 2, 0, 0, 0);
        check("async_reset_u3", 3, 0, 0, 0);
        #2 rst_n = 1'b1;
        mode_a[0] = MODE_UP;
        step();
        check("resume_1", 0, 1, 0, 0);
        step();
        check("resume_2", 0, 2, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
